orange_test_pattern_gen: RTL
============================

ORANGE_TEST_PATTERN_GEN -- requirements
Module: orange_test_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 320: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 240: active lines per frame.
REQ-003 Parameter H_BLANK, default 16: HREF-low cycles after each active line.
REQ-004 Parameter VS_CYCLES, default 4: VSYNC-high cycles at frame start.
REQ-005 Parameter VB_CYCLES, default 8: blank cycles between VSYNC fall and first active line.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  high = generate frames continuously.
REQ-009 box_x0, box_x1  input  9 each  orange box column bounds, x0 <= x < x1.
REQ-010 box_y0, box_y1  input  8 each  orange box row bounds, y0 <= y < y1.
REQ-011 VSYNC  output  1  frame-start pulse.
REQ-012 HREF  output  1  high during each active pixel.
REQ-013 red, green, blue  output  4 each  pixel colour, valid when HREF high.
REQ-014 is_orange  output  1  pixel lies inside the box; valid when HREF high.
REQ-015 pix_x  output  9  current column; pix_y  output  8  current row.
REQ-016 frame_done  output  1  one-cycle pulse after last blank of the last line.

Function
REQ-017 The block SHALL implement states IDLE, VS, VBLANK, ACTIVE, HBLANK.
REQ-018 IDLE: all outputs low/zero; enable high -> VS on the next edge.
REQ-019 On IDLE->VS and on every frame restart, box_x0/x1/y0/y1 SHALL be latched; mid-frame input changes SHALL have no effect until the next frame.
REQ-020 VS: VSYNC high exactly VS_CYCLES cycles, then VBLANK.
REQ-021 VBLANK: VB_CYCLES cycles, HREF low, then ACTIVE with pix_y=0.
REQ-022 ACTIVE: HREF high exactly H_ACTIVE consecutive cycles, pix_x 0..H_ACTIVE-1 incrementing by 1 per cycle, then HBLANK.
REQ-023 HBLANK: HREF low H_BLANK cycles, pix_x held 0; then pix_y increments and ACTIVE resumes, unless pix_y = V_ACTIVE-1.
REQ-024 After HBLANK of line V_ACTIVE-1: frame_done high one cycle (the first cycle after that HBLANK), pix_y wraps to 0; state -> VS if enable high, else IDLE.
REQ-025 Frame period SHALL be VS_CYCLES+VB_CYCLES+V_ACTIVE*(H_ACTIVE+H_BLANK)+1 cycles (defaults: 80653).
REQ-026 Inside box (latched bounds, ACTIVE): red=4'hF, green=4'h8, blue=4'h0, is_orange=1.
REQ-027 Outside box in ACTIVE: red=4'h0, green=4'h0, blue=4'hF, is_orange=0.
REQ-028 Outside ACTIVE: red/green/blue=0, is_orange=0.
REQ-029 All outputs SHALL be registered; HREF, colour, is_orange, pix_x, pix_y SHALL be mutually cycle-aligned.
REQ-030 box_x0 >= box_x1 or box_y0 >= box_y1 SHALL yield an empty box (no orange pixel); bounds beyond H_ACTIVE/V_ACTIVE are clipped naturally.
REQ-031 enable falling mid-frame SHALL not truncate the frame; the frame completes, then IDLE.
REQ-032 Counter comparisons SHALL be unsigned; counters sized to hold max parameter value without overflow.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE and all outputs and counters to 0, including mid-line; frame_done SHALL not pulse on reset.
REQ-034 After rst_n rises, first VSYNC SHALL appear no earlier than one cycle after enable is sampled high.

Verification
REQ-035 enable=1, box x 70..290, y 0..240 -> per frame 52800 is_orange pixels, zero in columns 0..69 and 290..319.
REQ-036 Default params, enable held -> VSYNC rising edges exactly 80653 cycles apart; 240 HREF pulses of 320 cycles each.
REQ-037 box_x0=100, box_x1=100 -> zero is_orange over a full frame; frame_done still pulses once.
REQ-038 box changed to x 0..10 during line 50 -> current frame unchanged; next frame 2400 orange pixels in columns 0..9.
REQ-039 enable dropped at line 120 -> frame runs to line 239, frame_done pulses, then IDLE with all outputs 0.
REQ-040 rst_n pulsed low at pix_x=150 of line 10 -> HREF and colours 0 same cycle as assertion; after release with enable=1, new frame starts with VS.

Source files
------------

// File: rtl/orange_test_pattern_gen.sv
// Camera-style test pattern source: VSYNC/HREF timing with an orange box
// drawn on a blue field. Box bounds are captured once per frame.
module orange_test_pattern_gen #(
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240,
    parameter int H_BLANK   = 16,
    parameter int VS_CYCLES = 4,
    parameter int VB_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [8:0] box_x0,
    input  logic [8:0] box_x1,
    input  logic [7:0] box_y0,
    input  logic [7:0] box_y1,
    output logic       VSYNC,
    output logic       HREF,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       is_orange,
    output logic [8:0] pix_x,
    output logic [7:0] pix_y,
    output logic       frame_done
);

    localparam int CMAX_A = (VS_CYCLES > VB_CYCLES) ? VS_CYCLES : VB_CYCLES;
    localparam int CMAX   = (CMAX_A > H_BLANK) ? CMAX_A : H_BLANK;
    localparam int CW     = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VS     = 3'd1,
        S_VBLANK = 3'd2,
        S_ACTIVE = 3'd3,
        S_HBLANK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic [8:0]    bx0_q, bx0_d, bx1_q, bx1_d;
    logic [7:0]    by0_q, by0_d, by1_q, by1_d;
    logic          frame_done_q, frame_done_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [3:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic          orange_q, orange_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus the counters that walk through the frame. The cycle
    // that carries frame_done is spent in IDLE, which is where a new frame
    // (and a fresh box capture) may begin.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        bx0_d        = bx0_q;
        bx1_d        = bx1_q;
        by0_d        = by0_q;
        by1_d        = by1_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                x_d = '0;
                y_d = '0;
                if (enable) begin
                    state_d = S_VS;
                    cnt_d   = '0;
                    bx0_d   = box_x0;
                    bx1_d   = box_x1;
                    by0_d   = box_y0;
                    by1_d   = box_y1;
                end
            end
            S_VS: begin
                if (cnt_q == CW'(VS_CYCLES - 1)) begin
                    state_d = S_VBLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_VBLANK: begin
                if (cnt_q == CW'(VB_CYCLES - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACTIVE: begin
                if (x_q == 9'(H_ACTIVE - 1)) begin
                    state_d = S_HBLANK;
                    cnt_d   = '0;
                    x_d     = '0;
                end else begin
                    x_d = x_q + 9'd1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == CW'(H_BLANK - 1)) begin
                    cnt_d = '0;
                    if (y_q == 8'(V_ACTIVE - 1)) begin
                        state_d      = S_IDLE;
                        y_d          = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = S_ACTIVE;
                        y_d     = y_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                x_d     = '0;
                y_d     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with pix_x/pix_y in the same cycle.
    always_comb begin
        vsync_d  = (state_d == S_VS);
        href_d   = (state_d == S_ACTIVE);
        orange_d = href_d && (x_d >= bx0_d) && (x_d < bx1_d)
                          && (y_d >= by0_d) && (y_d < by1_d);
        red_d    = 4'h0;
        green_d  = 4'h0;
        blue_d   = 4'h0;
        if (orange_d) begin
            red_d   = 4'hF;
            green_d = 4'h8;
        end else if (href_d) begin
            blue_d  = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            bx0_q        <= '0;
            bx1_q        <= '0;
            by0_q        <= '0;
            by1_q        <= '0;
            frame_done_q <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            orange_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bx0_q        <= bx0_d;
            bx1_q        <= bx1_d;
            by0_q        <= by0_d;
            by1_q        <= by1_d;
            frame_done_q <= frame_done_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
            orange_q     <= orange_d;
        end
    end

    assign VSYNC      = vsync_q;
    assign HREF       = href_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign is_orange  = orange_q;
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign frame_done = frame_done_q;

endmodule
